// File: rtl/speck_ts_ct_collector.sv
// speck_ts_ct_collector: read side of the bit-serial 3-share Speck128/128 core.
// Captures the three serial ciphertext shares after the last round, XOR-recombines
// them into ct_x/ct_y and offers the result on a valid/ready port.
// Optional build macro SHARE_OUT_EN exports the six raw captured share words.
`timescale 1ns/1ps

module speck_ts_ct_collector #(
   parameter int unsigned WORD  = 64,
   parameter int unsigned X_BIT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rndlessthan32,
   input  logic [1:0]      cipher_out1,
   input  logic [1:0]      cipher_out2,
   input  logic [1:0]      cipher_out3,
   input  logic            out_ready,
   input  logic            ovr_clr,
   output logic            out_valid,
   output logic [WORD-1:0] ct_x,
   output logic [WORD-1:0] ct_y,
   output logic            busy,
   output logic            overrun
`ifdef SHARE_OUT_EN
   ,
   output logic [WORD-1:0] sh1_x,
   output logic [WORD-1:0] sh1_y,
   output logic [WORD-1:0] sh2_x,
   output logic [WORD-1:0] sh2_y,
   output logic [WORD-1:0] sh3_x,
   output logic [WORD-1:0] sh3_y
`endif
);

   localparam int unsigned CW    = (WORD > 1) ? $clog2(WORD) : 1;
   localparam int unsigned NSH   = 6;
   localparam logic [CW-1:0] LAST = CW'(WORD - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAP, S_HOLD} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              rnd_q;
   logic              fall_c;
   logic              cap_en_c, ld_c, ovr_set_c, busy_d;
   logic              ld_q;
   logic              out_valid_q;
   logic [WORD-1:0]   ct_x_q, ct_y_q;
   logic              busy_q, overrun_q;
   logic [WORD-1:0]   sh_q [NSH];
   logic              bit_c [NSH];

   assign fall_c = rnd_q & ~rndlessthan32;

   // Serial bit selection: even index = x bit, odd index = y bit, per share
   always_comb begin
      bit_c[0] = (X_BIT != 0) ? cipher_out1[1] : cipher_out1[0];
      bit_c[1] = (X_BIT != 0) ? cipher_out1[0] : cipher_out1[1];
      bit_c[2] = (X_BIT != 0) ? cipher_out2[1] : cipher_out2[0];
      bit_c[3] = (X_BIT != 0) ? cipher_out2[0] : cipher_out2[1];
      bit_c[4] = (X_BIT != 0) ? cipher_out3[1] : cipher_out3[0];
      bit_c[5] = (X_BIT != 0) ? cipher_out3[0] : cipher_out3[1];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (rndlessthan32)             state_d = S_RUN;
         S_RUN:  if (fall_c)                    state_d = S_CAP;
         S_CAP:  if (cnt_q == LAST)             state_d = S_HOLD;
         S_HOLD: if (out_valid_q && out_ready)  state_d = S_IDLE;
         default:                               state_d = S_IDLE;
      endcase
   end

   // Control decode: capture enable, result load, overrun event, busy
   always_comb begin
      cap_en_c  = 1'b0;
      ld_c      = 1'b0;
      ovr_set_c = 1'b0;
      busy_d    = (state_d == S_RUN) || (state_d == S_CAP);
      unique case (state_q)
         S_RUN:  cap_en_c = fall_c;
         S_CAP: begin
            cap_en_c = 1'b1;
            ld_c     = (cnt_q == LAST);
         end
         S_HOLD: ovr_set_c = fall_c;
         S_IDLE: ovr_set_c = fall_c & out_valid_q;
         default: ;
      endcase
      cnt_d = cap_en_c ? cnt_q + CW'(1) : '0;
   end

   // Capture counter, round-flag history and load strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         rnd_q <= 1'b0;
         ld_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rnd_q <= rndlessthan32;
         ld_q  <= ld_c;
      end
   end

   // Share shift registers: LSB-first stream, new bit enters at the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSH; k++) sh_q[k] <= '0;
      end else if (cap_en_c) begin
         for (int k = 0; k < NSH; k++) sh_q[k] <= {bit_c[k], sh_q[k][WORD-1:1]};
      end
   end

   // Recombined result, handshake, busy and sticky overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         ct_x_q      <= '0;
         ct_y_q      <= '0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         busy_q <= busy_d;
         if (ld_q) begin
            ct_x_q      <= sh_q[0] ^ sh_q[2] ^ sh_q[4];
            ct_y_q      <= sh_q[1] ^ sh_q[3] ^ sh_q[5];
            out_valid_q <= 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (ovr_set_c)    overrun_q <= 1'b1;
         else if (ovr_clr) overrun_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign ct_x      = ct_x_q;
   assign ct_y      = ct_y_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

`ifdef SHARE_OUT_EN
   assign sh1_x = sh_q[0];
   assign sh1_y = sh_q[1];
   assign sh2_x = sh_q[2];
   assign sh2_y = sh_q[3];
   assign sh3_x = sh_q[4];
   assign sh3_y = sh_q[5];
`endif

endmodule
